// File: rtl/expcurve_pkg.sv
// Shared constants, FSM state encoding and flat-bus packing helper for the expcurve
// configuration sequencer.
package expcurve_pkg;

  localparam int DW_Y  = 9;
  localparam int N_Y1  = 48;
  localparam int N_Y2  = 9;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_Y1 = 2'd1,
    LOAD_Y2 = 2'd2,
    PEND    = 2'd3
  } state_t;

  function automatic int flat_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/expcurve_tbl_bank.sv
// Shadow/active label table: indexed writes land in the shadow copy, a commit strobe
// moves the whole shadow copy into the active copy, which drives the flat output bus.
module expcurve_tbl_bank
  import expcurve_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int WIDTH = 9,
  parameter int AW    = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   commit,
  output logic [DEPTH*WIDTH-1:0] flat
);

  logic [WIDTH-1:0] r_shadow [DEPTH];
  logic [WIDTH-1:0] r_active [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '{default: '0};
      r_active <= '{default: '0};
    end else begin
      // Decoded write keeps the index width independent of the table depth.
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_en && (wr_idx == AW'(k))) r_shadow[k] <= wr_data;
      end
      if (commit) r_active <= r_shadow;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat[flat_lo(g, WIDTH) +: WIDTH] = r_active[g];
  end

endmodule

// File: rtl/expcurve_cfg_ctrl.sv
// Curve configuration sequencer: streams 48 y1 + 9 y2 labels into shadow banks and commits
// them to the active banks on a frame boundary. Optional checker: EXPCURVE_MONO_CHK_EN.
module expcurve_cfg_ctrl #(
  parameter int DW_Y = expcurve_pkg::DW_Y,
  parameter int N_Y1 = expcurve_pkg::N_Y1,
  parameter int N_Y2 = expcurve_pkg::N_Y2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DW_Y-1:0]      cfg_data,
  input  logic                 frame_start,
  output logic [N_Y1*DW_Y-1:0] y1_flat,
  output logic [N_Y2*DW_Y-1:0] y2_flat,
  output logic                 busy,
  output logic                 pending,
  output logic                 swap_pulse,
  output logic                 err
);

  import expcurve_pkg::*;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_swap;
  logic               w_beat, w_wr_y1, w_wr_y2, w_commit, w_chk_bad;

  assign cfg_ready  = (r_state == LOAD_Y1) || (r_state == LOAD_Y2);
  assign busy       = (r_state != IDLE);
  assign pending    = (r_state == PEND) && !w_chk_bad;
  assign swap_pulse = r_swap;

  assign w_beat   = cfg_valid && cfg_ready;
  // A beat coinciding with load_start is dropped: the restart wins.
  assign w_wr_y1  = w_beat && (r_state == LOAD_Y1) && !load_start;
  assign w_wr_y2  = w_beat && (r_state == LOAD_Y2) && !load_start;
  assign w_commit = (r_state == PEND) && frame_start && !w_chk_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_swap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_swap  <= w_commit;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (load_start) begin
          w_state_nxt = LOAD_Y1;
          w_idx_nxt   = '0;
        end
      end
      LOAD_Y1: begin
        if (w_wr_y1) begin
          if (r_idx == IDX_W'(N_Y1 - 1)) begin
            w_state_nxt = LOAD_Y2;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      LOAD_Y2: begin
        if (w_wr_y2) begin
          if (r_idx == IDX_W'(N_Y2 - 1)) begin
            w_state_nxt = PEND;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      PEND: begin
        if (frame_start) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Restart from any state; in PEND the commit above still takes effect this edge.
    if (load_start) begin
      w_state_nxt = LOAD_Y1;
      w_idx_nxt   = '0;
    end
  end

`ifdef EXPCURVE_MONO_CHK_EN
  logic [DW_Y-1:0] r_prev;
  logic            r_fail, r_err;
  logic            w_beat_up, w_last_y2;

  // The first label of each table has no predecessor to compare against.
  assign w_beat_up = (w_wr_y1 || w_wr_y2) && (r_idx != '0) && (cfg_data > r_prev);
  assign w_last_y2 = w_wr_y2 && (r_idx == IDX_W'(N_Y2 - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_fail <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_y1 || w_wr_y2) r_prev <= cfg_data;
      if (load_start) begin
        r_fail <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_beat_up) r_fail <= 1'b1;
        if (w_last_y2 && (r_fail || w_beat_up)) r_err <= 1'b1;
      end
    end
  end

  assign w_chk_bad = r_err;
  assign err       = r_err;
`else
  assign w_chk_bad = 1'b0;
  assign err       = 1'b0;
`endif

  expcurve_tbl_bank #(.DEPTH(N_Y1), .WIDTH(DW_Y), .AW(IDX_W)) u_bank_y1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_y1),
    .wr_idx  (r_idx),
    .wr_data (cfg_data),
    .commit  (w_commit),
    .flat    (y1_flat)
  );

  expcurve_tbl_bank #(.DEPTH(N_Y2), .WIDTH(DW_Y), .AW(IDX_W)) u_bank_y2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_wr_y2),
    .wr_idx  (r_idx),
    .wr_data (cfg_data),
    .commit  (w_commit),
    .flat    (y2_flat)
  );

endmodule

// File: tb/tb_expcurve_cfg_ctrl.sv
// Directed bench for expcurve_cfg_ctrl: table-driven label checks plus hand-written
// sequences for reset, gaps, mid-load frame boundaries, restarts and the optional checker.
module tb_expcurve_cfg_ctrl;

  localparam int DW   = 9;
  localparam int NY1  = 48;
  localparam int NY2  = 9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_start = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [DW-1:0]   cfg_data = '0;
  logic            frame_start = 1'b0;
  logic [NY1*DW-1:0] y1_flat;
  logic [NY2*DW-1:0] y2_flat;
  logic            busy, pending, swap_pulse, err;

  expcurve_cfg_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .frame_start (frame_start),
    .y1_flat     (y1_flat),
    .y2_flat     (y2_flat),
    .busy        (busy),
    .pending     (pending),
    .swap_pulse  (swap_pulse),
    .err         (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pos   = 0;
  int src_y1 [NY1];
  int src_y2 [NY2];
  int m_y1   [NY1];
  int m_y2   [NY2];

  typedef struct {
    string name;
    int    tbl;
    int    k;
    int    exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int y1_at(input int k);
    return int'(y1_flat[k*DW +: DW]);
  endfunction

  function automatic int y2_at(input int k);
    return int'(y2_flat[k*DW +: DW]);
  endfunction

  // kind 0: y1=470-9k, y2=256-16k; 1: y1=400-k, y2=100-k; 2: flat 200/50;
  // 3: y1=300, y2=256-16k; 4: kind 0 with y1_5 = y1_4 + 1
  task automatic set_pat(input int kind);
    for (int k = 0; k < NY1; k++) begin
      case (kind)
        1:       src_y1[k] = 400 - k;
        2:       src_y1[k] = 200;
        3:       src_y1[k] = 300;
        default: src_y1[k] = 470 - 9 * k;
      endcase
    end
    for (int k = 0; k < NY2; k++) begin
      case (kind)
        1:       src_y2[k] = 100 - k;
        2:       src_y2[k] = 50;
        default: src_y2[k] = 256 - 16 * k;
      endcase
    end
    if (kind == 4) src_y1[5] = src_y1[4] + 1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    pos = 0;
  endtask

  // Offer labels until n have been accepted, with `gap` idle cycles after each offer.
  task automatic send(input int n, input int gap);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 500) begin
      cfg_valid = 1'b1;
      cfg_data  = DW'((pos < NY1) ? src_y1[pos] : src_y2[pos - NY1]);
      if (cfg_ready) begin
        sent++;
        pos++;
      end
      tick();
      cfg_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      guard++;
    end
    cfg_valid = 1'b0;
    if (sent < n) chk("send_timeout", sent, n);
  endtask

  task automatic commit_expect();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < NY1; k++) m_y1[k] = src_y1[k];
    for (int k = 0; k < NY2; k++) m_y2[k] = src_y2[k];
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NY1; k++) chk($sformatf("%s_y1_%0d", tag, k), y1_at(k), m_y1[k]);
    for (int k = 0; k < NY2; k++) chk($sformatf("%s_y2_%0d", tag, k), y2_at(k), m_y2[k]);
  endtask

  initial begin
    for (int k = 0; k < NY1; k++) m_y1[k] = 0;
    for (int k = 0; k < NY2; k++) m_y2[k] = 0;
    vecs[0] = '{"y1_0",  1, 0,  470};
    vecs[1] = '{"y1_1",  1, 1,  461};
    vecs[2] = '{"y1_10", 1, 10, 380};
    vecs[3] = '{"y1_47", 1, 47, 47};
    vecs[4] = '{"y2_0",  2, 0,  256};
    vecs[5] = '{"y2_4",  2, 4,  192};
    vecs[6] = '{"y2_7",  2, 7,  144};
    vecs[7] = '{"y2_8",  2, 8,  128};

    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_swap", swap_pulse, 0);
    chk("rst_err", err, 0);
    chk("rst_y1_zero", (y1_flat == '0), 1);

    // 1: reset in the middle of a load, then a full load from scratch
    set_pat(1);
    start_load();
    send(10, 0);
    chk("t1_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_ready", cfg_ready, 0);
    chk("t1_rst_pending", pending, 0);
    chk("t1_rst_y1", (y1_flat == '0), 1);
    chk("t1_rst_y2", (y2_flat == '0), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_idle_ready", cfg_ready, 0);
    start_load();
    send(56, 0);
    chk("t1_pend_at56", pending, 0);
    send(1, 0);
    chk("t1_pend_at57", pending, 1);
    commit_expect();
    chk("t1_swap", swap_pulse, 1);
    check_all("t1");

    // 2: back-to-back load of the reference curve
    set_pat(0);
    start_load();
    send(57, 0);
    chk("t2_pending", pending, 1);
    chk("t2_ready_pend", cfg_ready, 0);
    chk("t2_y1_old", y1_at(0), 400);
    commit_expect();
    chk("t2_swap", swap_pulse, 1);
    chk("t2_busy", busy, 0);
    chk("t2_pending_after", pending, 0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_%s", vecs[i].name),
          (vecs[i].tbl == 1) ? y1_at(vecs[i].k) : y2_at(vecs[i].k), vecs[i].exp);
    tick();
    chk("t2_swap_1cyc", swap_pulse, 0);

    // 3: every-other-cycle valids, then a surplus beat while pending
    start_load();
    send(56, 1);
    chk("t3_pend_at56", pending, 0);
    send(1, 1);
    chk("t3_pend_at57", pending, 1);
    chk("t3_ready_pend", cfg_ready, 0);
    cfg_valid = 1'b1;
    cfg_data  = 9'h1FF;
    tick();
    cfg_valid = 1'b0;
    chk("t3_still_pend", pending, 1);
    commit_expect();
    chk("t3_swap", swap_pulse, 1);
    check_all("t3");

    // 4: frame boundary during a load has no effect
    set_pat(2);
    start_load();
    send(20, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t4_no_swap", swap_pulse, 0);
    chk("t4_busy", busy, 1);
    check_all("t4mid");
    send(37, 0);
    chk("t4_pending", pending, 1);
    commit_expect();
    chk("t4_swap", swap_pulse, 1);
    check_all("t4");

    // 5: restart at beat 30 with a beat in the restart cycle
    set_pat(0);
    start_load();
    send(30, 0);
    set_pat(3);
    load_start = 1'b1;
    cfg_valid  = 1'b1;
    cfg_data   = 9'h1FF;
    tick();
    load_start = 1'b0;
    cfg_valid  = 1'b0;
    pos = 0;
    chk("t5_active_kept", y1_at(0), 200);
    send(56, 0);
    chk("t5_pend_at56", pending, 0);
    send(1, 0);
    chk("t5_pend_at57", pending, 1);
    commit_expect();
    check_all("t5");

    // load_start and frame_start together in PEND: commit and restart
    set_pat(0);
    start_load();
    send(57, 0);
    load_start  = 1'b1;
    frame_start = 1'b1;
    tick();
    load_start  = 1'b0;
    frame_start = 1'b0;
    for (int k = 0; k < NY1; k++) m_y1[k] = src_y1[k];
    for (int k = 0; k < NY2; k++) m_y2[k] = src_y2[k];
    pos = 0;
    chk("dual_swap", swap_pulse, 1);
    chk("dual_ready", cfg_ready, 1);
    chk("dual_pending", pending, 0);
    check_all("dual");
    set_pat(2);
    send(57, 0);
    commit_expect();
    check_all("dual_next");

    // 6: non-monotonic y1 curve
    set_pat(4);
    start_load();
    send(57, 0);
`ifdef EXPCURVE_MONO_CHK_EN
    chk("t6_err", err, 1);
    chk("t6_pending", pending, 0);
    chk("t6_busy", busy, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t6_no_swap", swap_pulse, 0);
    chk("t6_busy_drop", busy, 0);
    chk("t6_err_sticky", err, 1);
    check_all("t6");
    start_load();
    chk("t6_err_clr", err, 0);
`else
    chk("t6_err", err, 0);
    chk("t6_pending", pending, 1);
    commit_expect();
    chk("t6_swap", swap_pulse, 1);
    chk("t6_y1_5", y1_at(5), 435);
    check_all("t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
